// File: rtl/round_pkg.sv
// round_pkg: shared types and constants for the memory-game round controller.
//   state_e      - FSM state encoding (also driven onto the LED state port)
//   difficulty_e - show-phase speed selection
//   KEY_*        - keypad codes with fixed meaning
//   TIMER_W      - width of the shared down-counter
//   SCORE_MAX    - score saturation value
package round_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StShow  = 3'd2,
        StEntry = 3'd3,
        StCheck = 3'd4,
        StOver  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        DiffEasy = 2'd0,
        DiffMed  = 2'd1,
        DiffHard = 2'd2
    } difficulty_e;

    localparam logic [3:0] KEY_START = 4'hF;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_EASY  = 4'h1;
    localparam logic [3:0] KEY_MED   = 4'h2;
    localparam logic [3:0] KEY_HARD  = 4'h3;

    localparam int unsigned TIMER_W   = 32;
    localparam logic [13:0] SCORE_MAX = 14'd9999;

endpackage

// File: rtl/round_timer.sv
// round_timer: loadable down-counter shared by the show phase and the entry timeout.
//   clk, rst    - clock, asynchronous active-high reset
//   load        - load load_value (takes priority over dec)
//   load_value  - value to load
//   dec         - decrement by one (stops at zero)
//   last        - high when the count is at 1 or 0, i.e. it reaches zero on this decrement
module round_timer
    import round_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             last
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign last = (count_q <= WIDTH'(1));

endmodule

// File: rtl/round_controller.sv
// round_controller: sequencing FSM for a show-then-recall keypad game.
//   clk, rst     - single clock, asynchronous active-high reset
//   key_valid    - one-cycle keypad press strobe, key_code carries the hex key
//   seq_req/ack  - handshake with the sequence source, seq_data valid with seq_ack
//   show_number  - high while the target is displayed
//   target       - latched sequence
//   score        - rounds won (saturating), lives_left - remaining lives
//   entry_count  - digits entered in this attempt, state - encoded FSM state
// Optional feature: define ROUND_TIMEOUT_EN to end an ENTRY phase with a forced
// mismatch after TIMEOUT_TICKS cycles without an accepted key.
module round_controller
    import round_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned EASY_TICKS    = 7000000,
    parameter int unsigned MED_TICKS     = 5000000,
    parameter int unsigned HARD_TICKS    = 3000000,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned TIMEOUT_TICKS = 100000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic                  seq_req,
    input  logic                  seq_ack,
    input  logic [4*DIGITS-1:0]   seq_data,
    output logic                  show_number,
    output logic [4*DIGITS-1:0]   target,
    output logic [13:0]           score,
    output logic [1:0]            lives_left,
    output logic [2:0]            entry_count,
    output logic [2:0]            state
);

    state_e                state_q, state_d;
    difficulty_e           diff_q, diff_d;
    logic [4*DIGITS-1:0]   target_q, target_d;
    logic [4*DIGITS-1:0]   buf_q, buf_d;
    logic [13:0]           score_q, score_d;
    logic [1:0]            lives_q, lives_d;
    logic [2:0]            cnt_q, cnt_d;

    logic                  tmr_load, tmr_dec, tmr_last;
    logic [TIMER_W-1:0]    tmr_value, show_ticks;
    logic                  entry_match;

`ifdef ROUND_TIMEOUT_EN
    // Remembers that CHECK was reached by inactivity so it counts as a miss.
    logic timeout_q, timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= timeout_d;
    end

    assign entry_match = !timeout_q && (buf_q == target_q);
`else
    assign entry_match = (buf_q == target_q);
`endif

    always_comb begin
        unique case (diff_q)
            DiffMed:  show_ticks = TIMER_W'(MED_TICKS);
            DiffHard: show_ticks = TIMER_W'(HARD_TICKS);
            default:  show_ticks = TIMER_W'(EASY_TICKS);
        endcase
    end

    round_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        (tmr_dec),
        .last       (tmr_last)
    );

    always_comb begin
        state_d   = state_q;
        diff_d    = diff_q;
        target_d  = target_q;
        buf_d     = buf_q;
        score_d   = score_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_value = show_ticks;
`ifdef ROUND_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (key_valid) begin
                    if (key_code == KEY_EASY)      diff_d = DiffEasy;
                    else if (key_code == KEY_MED)  diff_d = DiffMed;
                    else if (key_code == KEY_HARD) diff_d = DiffHard;
                    else if (key_code == KEY_START) begin
                        score_d = '0;
                        lives_d = 2'(LIVES);
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (seq_ack) begin
                    target_d = seq_data;
                    tmr_load = 1'b1;
                    state_d  = StShow;
                end
            end
            StShow: begin
                if (tmr_last) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StEntry;
`ifdef ROUND_TIMEOUT_EN
                    tmr_load  = 1'b1;
                    tmr_value = TIMER_W'(TIMEOUT_TICKS);
`endif
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StEntry: begin
                if (key_valid && (key_code == KEY_CLEAR)) begin
                    buf_d = '0;
                    cnt_d = '0;
`ifdef ROUND_TIMEOUT_EN
                    tmr_load  = 1'b1;
                    tmr_value = TIMER_W'(TIMEOUT_TICKS);
`endif
                end else if (key_valid && (key_code != KEY_START)) begin
                    // Earlier digits move up so the first key ends in the top nibble.
                    buf_d = {buf_q[4*DIGITS-5:0], key_code};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'(DIGITS - 1)) begin
                        state_d = StCheck;
`ifdef ROUND_TIMEOUT_EN
                        timeout_d = 1'b0;
`endif
                    end
`ifdef ROUND_TIMEOUT_EN
                    tmr_load  = 1'b1;
                    tmr_value = TIMER_W'(TIMEOUT_TICKS);
`endif
                end else begin
`ifdef ROUND_TIMEOUT_EN
                    if (tmr_last) begin
                        timeout_d = 1'b1;
                        state_d   = StCheck;
                    end else begin
                        tmr_dec = 1'b1;
                    end
`endif
                end
            end
            StCheck: begin
                if (entry_match) begin
                    score_d = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 14'd1;
                    state_d = StFetch;
                end else if (lives_q <= 2'd1) begin
                    lives_d = '0;
                    state_d = StOver;
                end else begin
                    lives_d  = lives_q - 2'd1;
                    tmr_load = 1'b1;
                    state_d  = StShow;
                end
            end
            StOver: begin
                if (key_valid && (key_code == KEY_START)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            diff_q   <= DiffEasy;
            target_q <= '0;
            buf_q    <= '0;
            score_q  <= '0;
            lives_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            diff_q   <= diff_d;
            target_q <= target_d;
            buf_q    <= buf_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            cnt_q    <= cnt_d;
        end
    end

    assign seq_req     = (state_q == StFetch);
    assign show_number = (state_q == StShow);
    assign target      = target_q;
    assign score       = score_q;
    assign lives_left  = lives_q;
    assign entry_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: directed stimulus for round_controller with a behavioural
// reference model compared every cycle, plus hand-computed literal expectations.
module tb_round_controller;
    import round_pkg::*;

    localparam int DIGITS  = 4;
    localparam int EASY    = 7;
    localparam int MED     = 5;
    localparam int HARD    = 3;
    localparam int LIVES   = 3;
    localparam int TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        seq_req;
    logic        seq_ack;
    logic [15:0] seq_data;
    logic        show_number;
    logic [15:0] target;
    logic [13:0] score;
    logic [1:0]  lives_left;
    logic [2:0]  entry_count;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    round_controller #(
        .DIGITS        (DIGITS),
        .EASY_TICKS    (EASY),
        .MED_TICKS     (MED),
        .HARD_TICKS    (HARD),
        .LIVES         (LIVES),
        .TIMEOUT_TICKS (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .seq_req     (seq_req),
        .seq_ack     (seq_ack),
        .seq_data    (seq_data),
        .show_number (show_number),
        .target      (target),
        .score       (score),
        .lives_left  (lives_left),
        .entry_count (entry_count),
        .state       (state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    state_e      m_state;
    difficulty_e m_diff;
    int          m_target, m_score, m_lives, m_cnt, m_show_left, m_idle;
    bit          m_forced;
    logic [3:0]  m_digits [0:7];

    function automatic int ticks_for(difficulty_e d);
        if (d == DiffMed)  return MED;
        if (d == DiffHard) return HARD;
        return EASY;
    endfunction

    // Digits typed so far read as a hex number, first key most significant.
    function automatic int entry_value();
        int v = 0;
        for (int i = 0; i < m_cnt; i++) v = v * 16 + int'(m_digits[i]);
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= StIdle;   m_diff <= DiffEasy; m_target <= 0; m_score <= 0;
            m_lives <= 0;        m_cnt <= 0;         m_show_left <= 0;
            m_idle <= 0;         m_forced <= 1'b0;
        end else begin
            case (m_state)
                StIdle: if (key_valid) begin
                    if (key_code == 4'h1)      m_diff <= DiffEasy;
                    else if (key_code == 4'h2) m_diff <= DiffMed;
                    else if (key_code == 4'h3) m_diff <= DiffHard;
                    else if (key_code == 4'hF) begin
                        m_score <= 0; m_lives <= LIVES; m_state <= StFetch;
                    end
                end
                StFetch: if (seq_ack) begin
                    m_target <= int'(seq_data);
                    m_show_left <= ticks_for(m_diff);
                    m_state <= StShow;
                end
                StShow: begin
                    if (m_show_left <= 1) begin
                        m_state <= StEntry; m_cnt <= 0; m_idle <= 0;
                    end else begin
                        m_show_left <= m_show_left - 1;
                    end
                end
                StEntry: begin
                    if (key_valid && key_code == 4'hE) begin
                        m_cnt <= 0; m_idle <= 0;
                    end else if (key_valid && key_code != 4'hF) begin
                        m_digits[m_cnt] <= key_code;
                        m_cnt <= m_cnt + 1;
                        m_idle <= 0;
                        if (m_cnt + 1 == DIGITS) begin
                            m_state <= StCheck; m_forced <= 1'b0;
                        end
                    end else begin
                        m_idle <= m_idle + 1;
`ifdef ROUND_TIMEOUT_EN
                        if (m_idle + 1 >= TIMEOUT) begin
                            m_state <= StCheck; m_forced <= 1'b1;
                        end
`endif
                    end
                end
                StCheck: begin
                    if (!m_forced && entry_value() == m_target) begin
                        m_score <= (m_score >= 9999) ? 9999 : m_score + 1;
                        m_state <= StFetch;
                    end else begin
                        m_lives <= m_lives - 1;
                        if (m_lives <= 1) begin
                            m_state <= StOver;
                        end else begin
                            m_state <= StShow; m_show_left <= ticks_for(m_diff);
                        end
                    end
                end
                StOver: if (key_valid && key_code == 4'hF) m_state <= StIdle;
                default: m_state <= StIdle;
            endcase
        end
    end

    // Single compare process: all outputs against the model, every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_state", 32'(state), 32'(m_state));
            check("cyc_seq_req", 32'(seq_req), 32'(m_state == StFetch));
            check("cyc_show_number", 32'(show_number), 32'(m_state == StShow));
            check("cyc_target", 32'(target), m_target);
            check("cyc_score", 32'(score), m_score);
            check("cyc_lives_left", 32'(lives_left), m_lives);
            check("cyc_entry_count", 32'(entry_count), m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic enter4(input logic [15:0] v);
        logic [15:0] t;
        t = v;
        for (int i = 3; i >= 0; i--) press(t[4*i +: 4]);
    endtask

    task automatic ack(input logic [15:0] d);
        seq_ack  = 1'b1;
        seq_data = d;
        @(negedge clk);
        seq_ack  = 1'b0;
        seq_data = 16'h0;
    endtask

    task automatic wait_state(input state_e s, input int budget);
        int n = 0;
        while (state !== 3'(s) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", 32'(state), 32'(s));
    endtask

    task automatic count_show(output int n);
        n = 0;
        while (show_number === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; seq_ack = 1'b0; seq_data = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 32'(StIdle));
        check("rst_seq_req", 32'(seq_req), 0);
        check("rst_show", 32'(show_number), 0);
        check("rst_score", 32'(score), 0);
        check("rst_lives", 32'(lives_left), 0);
        check("rst_target", 32'(target), 0);
        rst = 1'b0;
        @(negedge clk);

        // Medium game start, source answers after 3 cycles.
        press(4'h2);
        press(4'hF);
        check("start_fetch", 32'(state), 32'(StFetch));
        check("start_lives", 32'(lives_left), 3);
        repeat (3) @(negedge clk);
        check("req_held", 32'(seq_req), 1);
        ack(16'h1234);
        check("latched_target", 32'(target), 32'h1234);
        count_show(n);
        check("show_len_med", n, MED);
        check("entry_after_show", 32'(state), 32'(StEntry));

        // Stray ack while entering must not touch the target.
        ack(16'hBEEF);
        enter4(16'h1234);
        check("in_check", 32'(state), 32'(StCheck));
        @(negedge clk);
        check("won_score", 32'(score), 1);
        check("req_again", 32'(seq_req), 1);

        // Round 2: clear mid-entry, F ignored.
        ack(16'h5678);
        wait_state(StEntry, 20);
        press(4'h5);
        press(4'h6);
        check("count_two", 32'(entry_count), 2);
        press(4'hE);
        check("count_cleared", 32'(entry_count), 0);
        press(4'hF);
        check("f_ignored", 32'(entry_count), 0);
        enter4(16'h5678);
        @(negedge clk);
        check("won_score2", 32'(score), 2);

        // Round 3: three misses end the game.
        ack(16'h9ABC);
        wait_state(StEntry, 20);
        enter4(16'h1111);
        @(negedge clk);
        check("miss1_replay", 32'(state), 32'(StShow));
        check("miss1_lives", 32'(lives_left), 2);
        press(4'h3);
        wait_state(StEntry, 20);
        enter4(16'h1111);
        @(negedge clk);
        check("miss2_replay", 32'(state), 32'(StShow));
        check("miss2_lives", 32'(lives_left), 1);
        wait_state(StEntry, 20);
        enter4(16'h2222);
        @(negedge clk);
        check("miss3_over", 32'(state), 32'(StOver));
        check("miss3_lives", 32'(lives_left), 0);
        press(4'hF);
        check("over_to_idle", 32'(state), 32'(StIdle));
        check("score_held", 32'(score), 2);

        // Hard game; key in FETCH must not change difficulty.
        press(4'h3);
        press(4'hF);
        check("restart_score", 32'(score), 0);
        press(4'h1);
        ack(16'h0001);
        count_show(n);
        check("show_len_hard", n, HARD);

`ifdef ROUND_TIMEOUT_EN
        n = 0;
        while (state === 3'(StEntry) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("timeout_len", n, TIMEOUT);
        @(negedge clk);
        check("timeout_lives", 32'(lives_left), 2);
        wait_state(StEntry, 20);
`else
        repeat (60) @(negedge clk);
        check("no_timeout", 32'(state), 32'(StEntry));
`endif
        enter4(16'h0001);
        @(negedge clk);
        check("fetch_before_rst", 32'(seq_req), 1);

        // Asynchronous reset mid-handshake.
        #2 rst = 1'b1;
        #1;
        check("async_rst_req", 32'(seq_req), 0);
        check("async_rst_state", 32'(state), 32'(StIdle));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_score", 32'(score), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 SHALL have parameter DIGITS, default 4: digits per sequence.
REQ-002 SHALL have parameter EASY_TICKS, default 7000000: show-phase duration, easy.
REQ-003 SHALL have parameter MED_TICKS, default 5000000: show-phase duration, medium.
REQ-004 SHALL have parameter HARD_TICKS, default 3000000: show-phase duration, hard.
REQ-005 SHALL have parameter LIVES, default 3: mismatches allowed per game.
REQ-006 SHALL have parameter TIMEOUT_TICKS, default 100000000: entry inactivity limit.
REQ-007 SHALL have port clk, input, 1: single clock; every register is in this one domain.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port key_valid, input, 1: one-cycle pulse per keypad press.
REQ-010 SHALL have port key_code, input, 4: hex key code, valid with key_valid.
REQ-011 SHALL have port seq_req, output, 1: request for a new sequence.
REQ-012 SHALL have port seq_ack, input, 1: sequence source ready.
REQ-013 SHALL have port seq_data, input, 4*DIGITS: sequence, valid with seq_ack.
REQ-014 SHALL have port show_number, output, 1: VGA shows the target when high.
REQ-015 SHALL have port target, output, 4*DIGITS: latched sequence.
REQ-016 SHALL have port score, output, 14: rounds won.
REQ-017 SHALL have port lives_left, output, 2: remaining lives.
REQ-018 SHALL have port entry_count, output, 3: digits entered this attempt.
REQ-019 SHALL have port state, output, 3: encoded FSM state, drives the LEDs.

Function
REQ-020 SHALL implement states IDLE, FETCH, SHOW, ENTRY, CHECK, OVER.
REQ-021 IDLE: keys 1, 2 and 3 SHALL select easy, medium and hard; key F SHALL clear score, load lives to LIVES and go to FETCH.
REQ-022 FETCH: seq_req SHALL be held high until the cycle seq_ack is high; that cycle SHALL latch seq_data into target, drop seq_req next cycle, and enter SHOW.
REQ-023 seq_ack outside FETCH SHALL be ignored.
REQ-024 On entering SHOW, the timer SHALL load the ticks for the current difficulty and show_number SHALL go high.
REQ-025 SHOW SHALL decrement the timer each cycle; at zero, show_number SHALL go low and the FSM SHALL enter ENTRY with entry buffer and entry_count cleared.
REQ-026 ENTRY: keys 0x0-0xD SHALL shift into the buffer low nibble first and increment entry_count; key E SHALL clear buffer and count; key F SHALL be ignored.
REQ-027 When entry_count reaches DIGITS, the FSM SHALL enter CHECK on the next cycle; keys arriving in CHECK SHALL be dropped.
REQ-028 CHECK lasts one cycle. On a match, score SHALL increment, saturating at 9999, and the FSM SHALL go to FETCH.
REQ-029 CHECK on a mismatch: lives_left SHALL decrement; at zero the FSM SHALL go to OVER, otherwise to SHOW replaying the same target.
REQ-030 Keys in FETCH, SHOW and CHECK SHALL be ignored.
REQ-031 OVER: key F SHALL return to IDLE; score SHALL hold until the next start.
REQ-032 Difficulty SHALL be latched only in IDLE.

Reset
REQ-033 Reset SHALL force IDLE with difficulty easy and seq_req, show_number, target, score, lives_left, entry_count and timers all 0, immediately and mid-handshake included.

Configuration
REQ-034 With ROUND_TIMEOUT_EN defined, an ENTRY inactivity counter SHALL restart on every accepted key; reaching TIMEOUT_TICKS SHALL enter CHECK forced as a mismatch.
REQ-035 Without ROUND_TIMEOUT_EN, ENTRY SHALL wait indefinitely and no timeout counter SHALL be synthesized.

Structure
REQ-036 Package round_pkg SHALL hold the state enum, difficulty enum and key-code constants (KEY_START=F, KEY_CLEAR=E).
REQ-037 Sub-module round_timer SHALL be the loadable down-counter shared by the show phase and the timeout.

Verification
REQ-038 Keys 2 then F, seq_ack after 3 cycles with data 0x1234 -> target=0x1234, show_number high for MED_TICKS cycles.
REQ-039 Enter keys 1,2,3,4 against 0x1234 -> score 0->1, seq_req reasserted the cycle after CHECK.
REQ-040 Enter 1,2,E,1,2,3,4 -> entry_count returns to 0 after E; round won.
REQ-041 Three mismatches with LIVES=3 -> replays after misses 1 and 2, OVER after miss 3, lives_left=0; key F -> IDLE.
REQ-042 Assert rst during FETCH with seq_req high -> seq_req=0 and state=IDLE in the same cycle.
REQ-043 With ROUND_TIMEOUT_EN and TIMEOUT_TICKS=50, no key for 50 cycles in ENTRY -> lives_left decrements.
